// File: rtl/mac_accumulator.sv
// Purpose: accumulates KLEN (activation, weight) products through an external PE,
//          then requantises the 31-bit sum to 16 bits (round, shift, optional ReLU, clip).
// Latency: out_valid asserts the cycle after the KLEN-th accepted term.
// Backpressure: holds the result until out_ready; in_ready stays low while holding.
// Ports: clk, rst_n, clr; in_valid/in_ready/in_data/in_weight term input;
//        pe_a/pe_b/pe_initsum/pe_result external PE link;
//        out_valid/out_ready/out_data/out_sat result output.
module mac_accumulator #(
  parameter int unsigned KLEN  = 9,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned RELU  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_weight,
  output logic [15:0] pe_a,
  output logic [15:0] pe_b,
  output logic [30:0] pe_initsum,
  input  logic [30:0] pe_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  localparam int unsigned CW   = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(KLEN - 1);
  localparam logic signed [31:0] RND = 32'sd1 <<< (SHIFT - 1);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [30:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   out_data_d;
  logic          out_sat_d;

  logic signed [31:0] rq_ext, rq_rnd, rq_shr, rq_relu;
  logic [15:0]        q_data;
  logic               q_sat;

  assign pe_a       = in_data;
  assign pe_b       = in_weight;
  assign pe_initsum = acc_q;

  // Requantise the PE output. The 32-bit extension leaves headroom for the
  // rounding add, so the largest 31-bit sum cannot wrap.
  always_comb begin
    rq_ext  = {pe_result[30], pe_result};
    rq_rnd  = rq_ext + RND;
    rq_shr  = rq_rnd >>> SHIFT;
    rq_relu = rq_shr;
    if (RELU != 0 && rq_shr < 0) rq_relu = '0;
    q_sat  = 1'b0;
    q_data = rq_relu[15:0];
    if (rq_relu > 32'sd32767) begin
      q_data = 16'h7FFF;
      q_sat  = 1'b1;
    end else if (rq_relu < -32'sd32767) begin
      // Symmetric clip: 0x8000 is never produced.
      q_data = 16'h8001;
      q_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data;
    out_sat_d  = out_sat;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == LAST) begin
            out_data_d = q_data;
            out_sat_d  = q_sat;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = OUT;
          end else begin
            acc_d = pe_result;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
    // Abort overrides any accept or handshake in the same cycle.
    if (clr) begin
      state_d    = ACC;
      acc_d      = '0;
      cnt_d      = '0;
      out_data_d = out_data;
      out_sat_d  = out_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_data <= out_data_d;
      out_sat  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic        out_ready = 1'b1;

  // Instance 1: RELU=1, instance 0: RELU=0; both share the input stream.
  logic        in_ready1, out_valid1, out_sat1;
  logic [15:0] pe_a1, pe_b1, out_data1;
  logic [30:0] pe_init1, pe_res1;
  logic        in_ready0, out_valid0, out_sat0;
  logic [15:0] pe_a0, pe_b0, out_data0;
  logic [30:0] pe_init0, pe_res0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural PE: a*b + s, saturated to the 31-bit two's complement range.
  function automatic logic [30:0] pe_model(input logic [15:0] a, input logic [15:0] b,
                                           input logic [30:0] s);
    longint t;
    longint hi;
    longint lo;
    hi = 64'sd1073741823;
    lo = -64'sd1073741824;
    t  = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(s));
    if (t > hi) return 31'h3FFF_FFFF;
    if (t < lo) return 31'h4000_0000;
    return t[30:0];
  endfunction

  assign pe_res1 = pe_model(pe_a1, pe_b1, pe_init1);
  assign pe_res0 = pe_model(pe_a0, pe_b0, pe_init0);

  mac_accumulator #(.KLEN(9), .SHIFT(8), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_weight(in_weight),
    .pe_a(pe_a1), .pe_b(pe_b1), .pe_initsum(pe_init1), .pe_result(pe_res1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
  );

  mac_accumulator #(.KLEN(9), .SHIFT(8), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_weight(in_weight),
    .pe_a(pe_a0), .pe_b(pe_b0), .pe_initsum(pe_init0), .pe_result(pe_res0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One term offered for one cycle; caller guarantees in_ready.
  task automatic push(input logic [15:0] d, input logic [15:0] w);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Nine identical terms; checks latency and both instances' results.
  task automatic run_group(input string name, input logic [15:0] d, input logic [15:0] w,
                           input logic [15:0] e1, input logic s1,
                           input logic [15:0] e0, input logic s0);
    for (int k = 0; k < 9; k++) begin
      check({name, ".in_ready"}, {31'b0, in_ready1 & in_ready0}, 32'd1);
      push(d, w);
      if (k == 7) check({name, ".early_valid"}, {31'b0, out_valid1 | out_valid0}, 32'd0);
    end
    check({name, ".out_valid"}, {30'b0, out_valid1, out_valid0}, 32'd3);
    check({name, ".relu1_data"}, {16'b0, out_data1}, {16'b0, e1});
    check({name, ".relu1_sat"}, {31'b0, out_sat1}, {31'b0, s1});
    check({name, ".relu0_data"}, {16'b0, out_data0}, {16'b0, e0});
    check({name, ".relu0_sat"}, {31'b0, out_sat0}, {31'b0, s0});
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, ".drained"}, {30'b0, out_valid1, out_valid0}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [15:0] w;
    logic [15:0] e1;
    logic        s1;
    logic [15:0] e0;
    logic        s0;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"unit",      16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0};
    vecs[1] = '{"neg",       16'hFF00, 16'h0100, 16'h0000, 1'b0, 16'hF700, 1'b0};
    vecs[2] = '{"pos_sat",   16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    vecs[3] = '{"neg_sat",   16'h8001, 16'h7FFF, 16'h0000, 1'b0, 16'h8001, 1'b1};
    vecs[4] = '{"small",     16'h0010, 16'h0010, 16'h0009, 1'b0, 16'h0009, 1'b0};
    vecs[5] = '{"round_up",  16'h0001, 16'h0080, 16'h0005, 1'b0, 16'h0005, 1'b0};
    vecs[6] = '{"round_neg", 16'hFFFF, 16'h0080, 16'h0000, 1'b0, 16'hFFFC, 1'b0};

    // Reset state
    #12;
    check("rst.out_valid", {30'b0, out_valid1, out_valid0}, 32'd0);
    check("rst.out_data", {out_data1, out_data0}, 32'd0);
    check("rst.out_sat", {30'b0, out_sat1, out_sat0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.in_ready", {30'b0, in_ready1, in_ready0}, 32'd3);

    // Table-driven groups
    for (int i = 0; i < 7; i++) begin
      run_group(vecs[i].name, vecs[i].d, vecs[i].w, vecs[i].e1, vecs[i].s1,
                vecs[i].e0, vecs[i].s0);
      drain(vecs[i].name);
    end

    // Backpressure: result held for 5 stalled cycles, stray input ignored
    out_ready = 1'b0;
    run_group("bp", 16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid  = 1'b1;
      in_data   = 16'h7FFF;
      in_weight = 16'h7FFF;
      @(posedge clk);
      #1;
      check("bp.out_valid", {31'b0, out_valid1}, 32'd1);
      check("bp.out_data", {16'b0, out_data1}, 32'h0900);
      check("bp.in_ready", {31'b0, in_ready1}, 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");
    // Stray terms must not have entered the next group
    run_group("post_bp", 16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0);
    drain("post_bp");

    // clr after 4 accepts, asserted together with a valid term
    for (int k = 0; k < 4; k++) push(16'h7FFF, 16'h7FFF);
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    in_weight = 16'h7FFF;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    run_group("clr_abort", 16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0);
    drain("clr_abort");

    // rst_n pulse after 4 accepts
    for (int k = 0; k < 4; k++) push(16'h7FFF, 16'h7FFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.in_ready", {30'b0, in_ready1, in_ready0}, 32'd3);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_group("rst_abort", 16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0);
    drain("rst_abort");

    // Reset while holding a result drops it
    out_ready = 1'b0;
    run_group("rst_out", 16'h0010, 16'h0010, 16'h0009, 1'b0, 16'h0009, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out.out_valid", {30'b0, out_valid1, out_valid0}, 32'd0);
    check("rst_out.out_data", {out_data1, out_data0}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out.still_idle", {30'b0, out_valid1, out_valid0}, 32'd0);

    // clr while holding a result, with out_ready low
    run_group("clr_out", 16'h0100, 16'h0100, 16'h0900, 1'b0, 16'h0900, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_out.out_valid", {30'b0, out_valid1, out_valid0}, 32'd0);
    check("clr_out.in_ready", {30'b0, in_ready1, in_ready0}, 32'd3);
    out_ready = 1'b1;
    run_group("after_clr", 16'hFF00, 16'h0100, 16'h0000, 1'b0, 16'hF700, 1'b0);
    drain("after_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
